// File: rtl/game_arbiter_if.sv
// Game-side bundle between game_arbiter (master) and the shared full_game instance (slave).
interface game_arbiter_if #(
    parameter int unsigned N = 4
);
    logic         game_init;
    logic [N-1:0] game_initial_val;
    logic [1:0]   game_control;
    logic         game_gameover;
    logic [1:0]   game_who;

    modport master (
        output game_init, game_initial_val, game_control,
        input  game_gameover, game_who
    );

    modport slave (
        input  game_init, game_initial_val, game_control,
        output game_gameover, game_who
    );
endinterface

// File: rtl/game_arbiter.sv
// Round-robin arbiter sharing one full_game between P players, with per-player win tallies.
// Optional feature: define GAME_TIMEOUT_EN to abort a PLAY session after TIMEOUT cycles.
module game_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned P       = 4,
    parameter int unsigned SW      = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [P-1:0]         req,
    input  logic [2*P-1:0]       player_ctrl,
    input  logic [N*P-1:0]       player_seed,
    output logic [P-1:0]         grant,
    game_arbiter_if.master       game,
    output logic                 done,
    output logic [1:0]           result,
    output logic [$clog2(P)-1:0] result_id,
    output logic [SW*P-1:0]      wins,
    output logic                 busy
);
    localparam int unsigned IW = $clog2(P);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, owner_q, owner_d, rid_d;
    logic [P-1:0]    grant_d;
    logic            init_q, init_d, done_d, busy_d;
    logic [N-1:0]    ival_q, ival_d;
    logic [1:0]      ctrl_q, ctrl_d, result_d;
    logic [SW-1:0]   wins_q [P];
    logic [SW-1:0]   wins_d [P];
    logic [N-1:0]    seed_a [P];
    logic [1:0]      ctrl_a [P];
    logic [IW-1:0]   sel, idx;
    logic            found;

`ifdef GAME_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    for (genvar i = 0; i < int'(P); i++) begin : g_player
        assign seed_a[i]           = player_seed[N*i +: N];
        assign ctrl_a[i]           = player_ctrl[2*i +: 2];
        assign wins[SW*i +: SW]    = wins_q[i];
    end

    assign game.game_init        = init_q;
    assign game.game_initial_val = ival_q;
    assign game.game_control     = ctrl_q;

    // First requester at or after ptr, wrapping.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < P; i++) begin
            idx = IW'((32'(ptr_q) + i) % P);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grant_d  = grant;
        init_d   = 1'b0;
        ival_d   = ival_q;
        ctrl_d   = ctrl_q;
        done_d   = 1'b0;
        result_d = result;
        rid_d    = result_id;
        wins_d   = wins_q;
`ifdef GAME_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d      = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    init_d       = 1'b1;
                    ival_d       = seed_a[sel];
                    ctrl_d       = ctrl_a[sel];
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                ctrl_d  = ctrl_a[owner_q];
`ifdef GAME_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = PLAY;
            end
            PLAY: begin
                ctrl_d = ctrl_a[owner_q];
                // Gameover beats abandon, which beats timeout; who == 0 is not an outcome.
                if (game.game_gameover && (game.game_who == 2'd1 || game.game_who == 2'd2)) begin
                    result_d = game.game_who;
                    done_d   = 1'b1;
                    rid_d    = owner_q;
                    state_d  = DONE;
                end else if (!req[owner_q]) begin
                    result_d = 2'd0;
                    done_d   = 1'b1;
                    rid_d    = owner_q;
                    state_d  = DONE;
                end
`ifdef GAME_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = 2'd3;
                    done_d   = 1'b1;
                    rid_d    = owner_q;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            DONE: begin
                grant_d = '0;
                ptr_d   = (owner_q == IW'(P - 1)) ? '0 : owner_q + IW'(1);
                if (result == 2'd2 && wins_q[owner_q] != '1)
                    wins_d[owner_q] = wins_q[owner_q] + SW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant     <= '0;
            init_q    <= 1'b0;
            ival_q    <= '0;
            ctrl_q    <= '0;
            done      <= 1'b0;
            result    <= '0;
            result_id <= '0;
            busy      <= 1'b0;
            wins_q    <= '{default: '0};
`ifdef GAME_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant     <= grant_d;
            init_q    <= init_d;
            ival_q    <= ival_d;
            ctrl_q    <= ctrl_d;
            done      <= done_d;
            result    <= result_d;
            result_id <= rid_d;
            busy      <= busy_d;
            wins_q    <= wins_d;
`ifdef GAME_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end
endmodule

// File: doc/game_arbiter.md
# game_arbiter

Shares one multimode-counter game instance (`full_game`) between P players using round-robin arbitration. It sequences each session:
- grant a requester;
- load that player's seed into the game with a one-cycle init pulse;
- forward that player's mode control while the game runs;
- capture the outcome when the game reports gameover, then release.

The block sits between the player-side request logic and the game instance, and keeps per-player saturating win tallies.

## Interface
- `N`, 4, counter width of the shared game (seed width)
- `P`, 4, number of players; 2..8
- `SW`, 4, width of each per-player win tally
- `TIMEOUT`, 1000, PLAY cycles before abort; used only with `GAME_TIMEOUT_EN`
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  P  per-player session request; level, held for the whole session
- `player_ctrl`  in  2*P  player i mode at bits [2i+1:2i]: 0 = +1, 1 = +2, 2 = -1, 3 = -2
- `player_seed`  in  N*P  player i initial value at bits [N*i+N-1:N*i]
- `grant`  out  P  one-hot owner of the game; all-zero when idle
- `game_init`  out  1  to game init; one-cycle pulse
- `game_initial_val`  out  N  to game initial_val
- `game_control`  out  2  to game control
- `game_gameover`  in  1  from game gameover
- `game_who`  in  2  from game who: 1 = lose, 2 = win
- `done`  out  1  one-cycle session-end pulse
- `result`  out  2  valid with done: 0 = abandoned, 1 = lose, 2 = win, 3 = timeout
- `result_id`  out  $clog2(P)  player index of the ended session, valid with done
- `wins`  out  SW*P  per-player saturating win counts; player i at [SW*i+SW-1:SW*i]
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - If `req` != 0, select the first requesting player starting at `ptr` and wrapping modulo P.
  - Register `owner`, set `grant[owner]`, go to LOAD.
  - After reset, `ptr` = 0.
- LOAD (exactly 1 cycle):
  - `game_init` = 1.
  - `game_initial_val` = seed of owner; `game_control` = ctrl of owner.
  - Go to PLAY.
- PLAY:
  - `game_init` = 0.
  - Each cycle, `game_control` registers `player_ctrl` of owner.
  - If `game_gameover` = 1 and `game_who` ∈ {1,2}: latch `result` = `game_who`, go to DONE.
  - Else if `req[owner]` = 0: `result` = 0, go to DONE.
  - `game_gameover` with `game_who` = 0 is ignored.
- DONE (1 cycle):
  - `done` = 1, `result_id` = owner.
  - `grant` cleared at the DONE→IDLE edge.
  - If `result` = 2, `wins[owner]` increments, saturating at 2^SW−1.
  - `ptr` = (owner+1) mod P.
  - Go to IDLE.
- Rotation guarantee: a continuously requesting player is granted within P sessions.
- `game_initial_val` holds its last value outside LOAD. `game_control` holds its last value outside LOAD/PLAY.

## Timing
- Reset values (async, immediate on `rst_n` low): `grant` 0, `game_init` 0, `game_initial_val` 0, `game_control` 0, `done` 0, `result` 0, `result_id` 0, `wins` all 0, `busy` 0. State = IDLE, `ptr` = 0.
- `req` is sampled in IDLE at edge k:
  - `grant` and `busy` are high from edge k+1 (LOAD).
  - `game_init` pulse is at cycle k+1.
  - PLAY starts at k+2.
- `game_control` lags `player_ctrl` by 1 cycle in PLAY.
- Gameover sampled at edge m: `done` is high in cycle m+1; `grant` falls at m+2.
- Minimum one IDLE cycle between sessions. Back-to-back session spacing: DONE, IDLE, LOAD.
- Simultaneous gameover and `req[owner]` drop: gameover wins, result recorded.
- `req` changes by non-owners during a session are ignored.
- Reset mid-session: everything cleared. No `done` pulse, no tally update.

## Configuration
- `GAME_TIMEOUT_EN` defined:
  - A PLAY cycle counter of width $clog2(TIMEOUT+1) clears in LOAD.
  - After TIMEOUT PLAY cycles without gameover or abandon: `result` = 3, go to DONE, no tally change.
  - Gameover in the same cycle as expiry takes priority.
- Not defined: PLAY waits indefinitely, no counter is present, `result` never equals 3.

## Test plan
- Reset, `req` = 0001, seed 4'hE, ctrl 0; game returns gameover with who = 2 → `game_init` pulse 1 cycle with val 14; `done` with `result` = 2, `result_id` = 0; `wins[0]` = 1.
- `req` = 1111 held across 5 sessions → grant order 0, 1, 2, 3, 0; each `done` 3 cycles apart minimum.
- Player 2 in PLAY drops `req` → `done`, `result` = 0, `result_id` = 2; `wins` unchanged; next grant goes to player 3 if requesting.
- Gameover (who = 1) in the same cycle `req[owner]` falls → `result` = 1.
- With SW = 4, player 1 wins 17 times → `wins[1]` stays 15.
- `GAME_TIMEOUT_EN`, TIMEOUT = 10, no gameover → `done` at PLAY cycle 10 with `result` = 3. `rst_n` low mid-PLAY → outputs 0 immediately, no `done`.
